// File: rtl/sorted_chunk_merger.sv
// sorted_chunk_merger: collects a batch of 8-beat sorted chunks, then k-way merges the chunk
// heads into one fully sorted AXI-stream. Define SORTED_CHUNK_MERGER_SIGNED_EN for signed key order.
module sorted_chunk_merger #(
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 32,
  parameter int DEST_WIDTH      = 32,
  parameter int MAX_SORT_LENGTH = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$clog2(MAX_SORT_LENGTH):0] i_data_length,
  input  logic [DATA_WIDTH-1:0]            i_data_in_data,
  input  logic [USER_WIDTH-1:0]            i_data_in_user,
  input  logic [DEST_WIDTH-1:0]            i_data_in_dest,
  input  logic                             i_data_in_valid,
  output logic                             o_data_in_ready,
  output logic [DATA_WIDTH-1:0]            o_data_out_data,
  output logic [USER_WIDTH-1:0]            o_data_out_user,
  output logic [DEST_WIDTH-1:0]            o_data_out_dest,
  output logic                             o_data_out_valid,
  output logic                             o_data_out_last,
  input  logic                             i_data_out_ready
);
  localparam int NCH = MAX_SORT_LENGTH / 8;
  localparam int LW  = $clog2(MAX_SORT_LENGTH) + 1;
  localparam int AW  = $clog2(MAX_SORT_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_MERGE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_buf_data [MAX_SORT_LENGTH];
  logic [USER_WIDTH-1:0] r_buf_user [MAX_SORT_LENGTH];
  logic [DEST_WIDTH-1:0] r_buf_dest [MAX_SORT_LENGTH];

  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_wp;
  logic [LW-1:0]         r_oc;
  logic [3:0]            r_rp [NCH];
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [USER_WIDTH-1:0] r_out_user;
  logic [DEST_WIDTH-1:0] r_out_dest;

  logic [LW-1:0]         w_len_in;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_addr;
  logic                  w_out_free;
  logic [3:0]            w_len_c [NCH];
  logic                  w_live [NCH];
  logic [AW-1:0]         w_head_addr [NCH];
  logic                  w_found;
  logic [AW-1:0]         w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_key;
  logic [NCH-1:0]        w_win_oh;

  function automatic logic key_lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef SORTED_CHUNK_MERGER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  assign w_len_in   = (i_data_length > LW'(MAX_SORT_LENGTH)) ? LW'(MAX_SORT_LENGTH) : i_data_length;
  assign w_accept   = i_data_in_valid && o_data_in_ready;
  assign w_start    = w_accept && (r_state == S_IDLE) && (w_len_in != '0);
  assign w_wr_en    = w_start || (w_accept && (r_state == S_FILL));
  assign w_wr_addr  = (r_state == S_IDLE) ? '0 : r_wp[AW-1:0];
  assign w_out_free = !r_out_valid || i_data_out_ready;

  // Chunk lengths follow from the latched batch size: full chunks, one partial tail, then empty.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    assign w_len_c[gi] = (r_len >= LW'((gi + 1) * 8)) ? 4'd8 :
                         (r_len >  LW'(gi * 8))       ? 4'(r_len - LW'(gi * 8)) : 4'd0;
    assign w_live[gi]      = r_rp[gi] < w_len_c[gi];
    assign w_head_addr[gi] = AW'(gi * 8) | AW'(r_rp[gi][2:0]);
  end

  // Strict less-than while scanning upward keeps the lowest chunk on ties, making the merge stable.
  always_comb begin
    w_found    = 1'b0;
    w_win_addr = '0;
    w_win_key  = '0;
    w_win_oh   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_live[c] && (!w_found || key_lt(r_buf_data[w_head_addr[c]], w_win_key))) begin
        w_found     = 1'b1;
        w_win_addr  = w_head_addr[c];
        w_win_key   = r_buf_data[w_head_addr[c]];
        w_win_oh    = '0;
        w_win_oh[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_buf_data[w_wr_addr] <= i_data_in_data;
      r_buf_user[w_wr_addr] <= i_data_in_user;
      r_buf_dest[w_wr_addr] <= i_data_in_dest;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    o_data_in_ready = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = (w_len_in == LW'(1)) ? S_MERGE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept && (r_wp == r_len - LW'(1))) begin
          w_state_next = S_MERGE;
        end
      end
      S_MERGE: begin
        o_data_in_ready = 1'b0;
        if (r_out_valid && r_out_last && i_data_out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len       <= '0;
      r_wp        <= '0;
      r_oc        <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= '0;
      r_out_dest  <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_rp[c] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len <= w_len_in;
            r_wp  <= LW'(1);
            r_oc  <= '0;
            for (int c = 0; c < NCH; c++) begin
              r_rp[c] <= '0;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_wp <= r_wp + LW'(1);
          end
        end
        S_MERGE: begin
          if (w_out_free) begin
            if (r_out_valid && r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else if (w_found) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_win_key;
              r_out_user  <= r_buf_user[w_win_addr];
              r_out_dest  <= r_buf_dest[w_win_addr];
              r_oc        <= r_oc + LW'(1);
              r_out_last  <= (r_oc + LW'(1)) == r_len;
              for (int c = 0; c < NCH; c++) begin
                if (w_win_oh[c]) begin
                  r_rp[c] <= r_rp[c] + 4'd1;
                end
              end
            end else begin
              r_out_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data_out_valid = r_out_valid;
  assign o_data_out_last  = r_out_last;
  assign o_data_out_data  = r_out_data;
  assign o_data_out_user  = r_out_user;
  assign o_data_out_dest  = r_out_dest;

  // The upstream sorter ignores ready, so a beat offered while merging would be lost.
  a_no_beat_while_busy: assert property (@(posedge clock) disable iff (!reset)
    !(i_data_in_valid && !o_data_in_ready));

endmodule
